// File: rtl/queue_index_dispatcher_pkg.sv
// Shared definitions for the input-queue read-side dispatcher: boolean
// constants, queue sizing and the dispatcher FSM state encoding.
package queue_index_dispatcher_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Number of input pixels; the queue can never hold more indices than this.
    localparam int INPUT_LAYER_NODES = 10;
    localparam int QUEUE_MAX_SIZE    = INPUT_LAYER_NODES;

    // Dispatcher states, 3-bit encoded.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SETTLE  = 3'd2,
        CHECK   = 3'd3,
        POP     = 3'd4,
        CAPTURE = 3'd5,
        HOLD    = 3'd6,
        DONE    = 3'd7
    } dispatchState_t;

endpackage

// File: rtl/queue_index_dispatcher.sv
// Read-side controller for the input-pixel queue. Snapshots the queue into the
// QueueBuffer, pops every active-pixel index and hands each one downstream over
// a valid/ready handshake, counting accepted indices and pulsing done at the end.
module queue_index_dispatcher
    import queue_index_dispatcher_pkg::*;
#(
    parameter int INDEX_WIDTH = 10,
    parameter int COUNT_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   queueFinished,
    input  logic                   queueEmpty,
    input  logic [INDEX_WIDTH-1:0] queueIndexIn,
    output logic                   queueWriteEnable,
    output logic                   queueDequeue,
    output logic [INDEX_WIDTH-1:0] indexOut,
    output logic                   indexValid,
    input  logic                   indexReady,
    output logic [COUNT_WIDTH-1:0] indexCount,
    output logic                   busy,
    output logic                   done
);

    dispatchState_t state;

    // Single FSM with registered outputs: each pulse is set on the edge that
    // enters its state, so it is high for exactly that one state cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            queueWriteEnable <= FALSE;
            queueDequeue     <= FALSE;
            indexOut         <= '0;
            indexValid       <= FALSE;
            indexCount       <= '0;
            busy             <= FALSE;
            done             <= FALSE;
        end else begin
            queueWriteEnable <= FALSE;
            queueDequeue     <= FALSE;
            done             <= FALSE;
            case (state)
                IDLE: begin
                    // A start without a finished queue is dropped, not remembered.
                    if (start && queueFinished) begin
                        state            <= LOAD;
                        queueWriteEnable <= TRUE;
                        busy             <= TRUE;
                        indexCount       <= '0;
                    end
                end
                LOAD: begin
                    state <= SETTLE;
                end
                SETTLE: begin
                    // Give the buffer one cycle to update its pointers after the snapshot.
                    state <= CHECK;
                end
                CHECK: begin
                    if (queueEmpty) begin
                        state <= DONE;
                        done  <= TRUE;
                    end else begin
                        state        <= POP;
                        queueDequeue <= TRUE;
                    end
                end
                POP: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    indexOut   <= queueIndexIn;
                    indexValid <= TRUE;
                    state      <= HOLD;
                end
                HOLD: begin
                    // indexValid only drops together with an accepted transfer.
                    if (indexValid && indexReady) begin
                        indexValid <= FALSE;
                        state      <= CHECK;
                        if (indexCount != {COUNT_WIDTH{1'b1}}) begin
                            indexCount <= indexCount + COUNT_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    busy  <= FALSE;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_queue_index_dispatcher.sv
// Self-checking bench for queue_index_dispatcher, with a behavioural QueueBuffer
// model around the DUT and an index-list reference model derived from the pixels.
module tb_queue_index_dispatcher;

    logic       clk;
    logic       reset;
    logic       start;
    logic       queueFinished;
    logic       queueEmpty;
    logic [9:0] queueIndexIn;
    logic       queueWriteEnable;
    logic       queueDequeue;
    logic [9:0] indexOut;
    logic       indexValid;
    logic       indexReady;
    logic [9:0] indexCount;
    logic       busy;
    logic       done;

    bit [9:0] pixels;
    int       readyMode;
    int       bufQ[$];
    int       gotQ[$];
    int       expQ[$];
    int       weCnt, deqCnt, doneCnt, weCycle, doneCycle, cycle;
    int       checks, failures;
    logic     prevValid, prevReady, prevWE, prevDeq;
    logic [9:0] prevIndex;

    typedef struct {
        bit [9:0] pixels;
        int       readyMode;
        int       expCount;
        int       expIdx [10];
    } vector_t;
    vector_t vectors [5];

    queue_index_dispatcher #(.INDEX_WIDTH(10), .COUNT_WIDTH(10)) dut (
        .clk(clk), .reset(reset), .start(start), .queueFinished(queueFinished),
        .queueEmpty(queueEmpty), .queueIndexIn(queueIndexIn),
        .queueWriteEnable(queueWriteEnable), .queueDequeue(queueDequeue),
        .indexOut(indexOut), .indexValid(indexValid), .indexReady(indexReady),
        .indexCount(indexCount), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // QueueBuffer model: snapshot on writeEnable, registered pop on dequeue.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            bufQ.delete();
            queueIndexIn <= '0;
            queueEmpty   <= 1'b1;
        end else begin
            if (queueWriteEnable) begin
                bufQ.delete();
                for (int i = 0; i < 10; i++) if (pixels[i]) bufQ.push_back(i);
            end
            if (queueDequeue && bufQ.size() > 0) begin
                queueIndexIn <= 10'(bufQ[0]);
                bufQ.delete(0);
            end
            queueEmpty <= (bufQ.size() == 0);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Downstream ready driver, updated just after each rising edge.
    initial begin
        int holdCnt;
        holdCnt = 0;
        indexReady = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: indexReady = 1'b1;
                1: begin
                    if (indexValid) begin
                        indexReady = (holdCnt >= 3);
                        holdCnt++;
                    end else begin
                        holdCnt = 0;
                        indexReady = 1'b0;
                    end
                end
                2: indexReady = 1'($urandom_range(0, 1));
                default: indexReady = 1'b0;
            endcase
        end
    end

    // Protocol monitor: records accepted indices and pulses, checks handshake rules.
    initial begin
        cycle = 0;
        prevValid = 0; prevReady = 0; prevWE = 0; prevDeq = 0; prevIndex = '0;
        forever begin
            @(negedge clk);
            cycle++;
            if (!reset) begin
                prevValid = 0; prevReady = 0; prevWE = 0; prevDeq = 0;
            end else begin
                if (prevValid && !prevReady) begin
                    checkOutput("validHeld", 32'(indexValid), 32'd1);
                    checkOutput("indexStable", 32'(indexOut), 32'(prevIndex));
                end
                if (indexValid && indexReady) gotQ.push_back(int'(indexOut));
                if (queueWriteEnable || queueDequeue)
                    checkOutput("weDeqOneHot", 32'(queueWriteEnable && queueDequeue), 32'd0);
                if (queueWriteEnable) begin
                    weCnt++; weCycle = cycle;
                    checkOutput("weWidth", 32'(prevWE), 32'd0);
                end
                if (queueDequeue) begin
                    deqCnt++;
                    checkOutput("deqWidth", 32'(prevDeq), 32'd0);
                end
                if (done) begin doneCnt++; doneCycle = cycle; end
                prevValid = indexValid; prevReady = indexReady; prevIndex = indexOut;
                prevWE = queueWriteEnable; prevDeq = queueDequeue;
            end
        end
    end

    // Reference model: the active pixel indices in ascending order.
    function automatic void buildExpected(input bit [9:0] pix);
        expQ.delete();
        for (int i = 0; i < 10; i++) if (pix[i]) expQ.push_back(i);
    endfunction

    // Runs one batch: pulse start, optionally re-pulse it mid-batch, wait for done.
    task automatic applyStimulus(input bit [9:0] pix, input int mode, input bit midStart);
        int waitCycles;
        pixels = pix; readyMode = mode;
        gotQ.delete(); weCnt = 0; deqCnt = 0; doneCnt = 0;
        @(posedge clk); #1;
        queueFinished = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waitCycles = 0;
        while (doneCnt == 0 && waitCycles < 400) begin
            @(posedge clk); #1;
            waitCycles++;
            start = (midStart && (waitCycles == 6 || waitCycles == 13));
        end
        start = 1'b0;
        checkOutput("doneTimeout", 32'(doneCnt != 0), 32'd1);
    endtask

    // Compares a completed batch against expQ.
    task automatic checkBatch(input string tag);
        repeat (4) @(negedge clk);
        checkOutput({tag, ".numAccepted"}, 32'(gotQ.size()), 32'(expQ.size()));
        for (int i = 0; i < gotQ.size() && i < expQ.size(); i++)
            checkOutput({tag, ".index"}, 32'(gotQ[i]), 32'(expQ[i]));
        checkOutput({tag, ".indexCount"}, 32'(indexCount), 32'(expQ.size()));
        checkOutput({tag, ".writeEnables"}, 32'(weCnt), 32'd1);
        checkOutput({tag, ".dequeues"}, 32'(deqCnt), 32'(expQ.size()));
        checkOutput({tag, ".donePulses"}, 32'(doneCnt), 32'd1);
        checkOutput({tag, ".busyAfter"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int waitCycles;
        checks = 0; failures = 0;
        start = 0; queueFinished = 0; pixels = '0; readyMode = 0;
        weCnt = 0; deqCnt = 0; doneCnt = 0; weCycle = 0; doneCycle = 0;
        reset = 1'b1;
        #3 reset = 1'b0;
        #1;
        checkOutput("resetOutputs",
            32'({queueWriteEnable, queueDequeue, indexOut, indexValid, indexCount, busy, done}), 32'd0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;

        vectors[0] = '{pixels: 10'b1010110100, readyMode: 0, expCount: 5, expIdx: '{2,4,5,7,9,0,0,0,0,0}};
        vectors[1] = '{pixels: 10'b0011011011, readyMode: 1, expCount: 6, expIdx: '{0,1,3,4,6,7,0,0,0,0}};
        vectors[2] = '{pixels: 10'b0000000000, readyMode: 0, expCount: 0, expIdx: '{0,0,0,0,0,0,0,0,0,0}};
        vectors[3] = '{pixels: 10'b1111111111, readyMode: 0, expCount: 10, expIdx: '{0,1,2,3,4,5,6,7,8,9}};
        vectors[4] = '{pixels: 10'b1000000001, readyMode: 1, expCount: 2, expIdx: '{0,9,0,0,0,0,0,0,0,0}};

        for (int v = 0; v < 5; v++) begin
            expQ.delete();
            for (int k = 0; k < vectors[v].expCount; k++) expQ.push_back(vectors[v].expIdx[k]);
            applyStimulus(vectors[v].pixels, vectors[v].readyMode, 1'b0);
            checkBatch($sformatf("vec%0d", v));
            if (vectors[v].expCount == 0)
                checkOutput("emptyDoneLatency", 32'(doneCycle - weCycle), 32'd3);
        end

        // start without a finished queue is dropped.
        queueFinished = 1'b0; weCnt = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checkOutput("notFinished.busy", 32'(busy), 32'd0);
        end
        checkOutput("notFinished.writeEnables", 32'(weCnt), 32'd0);
        buildExpected(10'b0000100001);
        applyStimulus(10'b0000100001, 0, 1'b0);
        checkBatch("afterDrop");

        // start re-pulsed mid-batch is ignored.
        buildExpected(10'b1010110100);
        applyStimulus(10'b1010110100, 0, 1'b1);
        checkBatch("midStart");

        // Reset during HOLD of the third index, then rerun.
        pixels = 10'b1010110100; readyMode = 1;
        gotQ.delete();
        @(posedge clk); #1 queueFinished = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        waitCycles = 0;
        while (!(gotQ.size() == 2 && indexValid) && waitCycles < 200) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("thirdHoldReached", 32'(gotQ.size() == 2 && indexValid), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("midResetOutputs",
            32'({queueWriteEnable, queueDequeue, indexOut, indexValid, indexCount, busy, done}), 32'd0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        buildExpected(10'b1010110100);
        applyStimulus(10'b1010110100, 0, 1'b0);
        checkBatch("afterReset");

        // Randomized batches with random downstream back-pressure.
        for (int r = 0; r < 8; r++) begin
            bit [9:0] pix;
            pix = 10'($urandom_range(0, 1023));
            buildExpected(pix);
            applyStimulus(pix, 2, 1'(r % 2));
            checkBatch($sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
